// File: rtl/bcd_to_ex3.sv
// BCD digit to excess-3 encoder with invalid-code flag and saturating error count.
// Latency: exactly one cycle from a valid input to out_valid/s3..s0/err.
// Backpressure: none; accepts a digit every cycle, output holds while in_valid is low.
module bcd_to_ex3 #(
  parameter int          ERR_CNT_W   = 8,
  parameter logic [3:0]  INVALID_OUT = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
  output logic                 s0,
  output logic                 s1,
  output logic                 s2,
  output logic                 s3,
  output logic                 out_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Combinational core signals
  logic       invalid_code;
  logic [3:0] ex3_code;
  logic       cnt_full;

  // Registered state
  logic [3:0]           x_q,         x_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q,       err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  // Gate-level excess-3 core; only meaningful for v = 0..9, invalid codes are masked below.
  always_comb begin
    invalid_code = a & (b | c);
    ex3_code[0]  = ~d;
    ex3_code[1]  = ~(c ^ d);
    ex3_code[2]  = b ^ (c | d);
    ex3_code[3]  = a | (b & (c | d));
    cnt_full     = &err_cnt_q;
  end

  // Next-state: load on valid, hold the code word otherwise; counter saturates at all-ones.
  always_comb begin
    x_d         = x_q;
    out_valid_d = in_valid;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (in_valid) begin
      if (invalid_code) begin
        x_d   = INVALID_OUT;
        err_d = 1'b1;
        if (!cnt_full) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end else begin
        x_d = ex3_code;
      end
    end
  end

  // State registers with synchronous active-low reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= 4'b0000;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Outputs come straight from flops, so there is no input-to-output combinational path.
  always_comb begin
    s0        = x_q[0];
    s1        = x_q[1];
    s2        = x_q[2];
    s3        = x_q[3];
    out_valid = out_valid_q;
    err       = err_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_bcd_to_ex3.sv
// Self-checking bench for bcd_to_ex3: vector table, hand sequences, randomized run vs. model.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after the next rising edge.
// The DUT has no backpressure, so every step is a fixed single clock cycle.
module tb_bcd_to_ex3;

  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 a, b, c, d;
  logic                 s0, s1, s2, s3;
  logic                 out_valid;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state
  int m_x;
  int m_ov;
  int m_err;
  int m_cnt;

  typedef struct {
    int v;
    int vld;
    int ex;
    int eov;
    int eerr;
    int ecnt;
  } vec_t;

  vec_t tbl[$];

  bcd_to_ex3 #(.ERR_CNT_W(ERR_CNT_W), .INVALID_OUT(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .out_valid (out_valid),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dut_x();
    return int'({s3, s2, s1, s0});
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: excess-3 is value+3 for BCD digits, anything >= 10 is an error code.
  task automatic model_step(input int rst, input int vld, input int v);
    if (rst == 0) begin
      m_x = 0; m_ov = 0; m_err = 0; m_cnt = 0;
    end else if (vld != 0) begin
      m_ov = 1;
      if (v <= 9) begin
        m_x = v + 3; m_err = 0;
      end else begin
        m_x = 0; m_err = 1;
        m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
    end else begin
      m_ov = 0; m_err = 0;
    end
  endtask

  // Drive one cycle of stimulus, clock it in, and leave time at the sample point.
  task automatic step(input int rst, input int vld, input int v);
    logic [3:0] vv;
    vv       = v[3:0];
    rst_n    = (rst != 0);
    in_valid = (vld != 0);
    {a, b, c, d} = vv;
    model_step(rst, vld, v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"},   dut_x(),        m_x);
    check({tag, "_ov"},  int'(out_valid), m_ov);
    check({tag, "_err"}, int'(err),       m_err);
    check({tag, "_cnt"}, int'(err_cnt),   m_cnt);
  endtask

  function automatic vec_t mk(int v, int vld, int ex, int eov, int eerr, int ecnt);
    vec_t t;
    t.v = v; t.vld = vld; t.ex = ex; t.eov = eov; t.eerr = eerr; t.ecnt = ecnt;
    return t;
  endfunction

  initial begin
    // Sweep 0..9, invalid 10..15, then hold behaviour.
    tbl.push_back(mk(0,  1, 4'b0011, 1, 0, 0));
    tbl.push_back(mk(1,  1, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(2,  1, 4'b0101, 1, 0, 0));
    tbl.push_back(mk(3,  1, 4'b0110, 1, 0, 0));
    tbl.push_back(mk(4,  1, 4'b0111, 1, 0, 0));
    tbl.push_back(mk(5,  1, 4'b1000, 1, 0, 0));
    tbl.push_back(mk(6,  1, 4'b1001, 1, 0, 0));
    tbl.push_back(mk(7,  1, 4'b1010, 1, 0, 0));
    tbl.push_back(mk(8,  1, 4'b1011, 1, 0, 0));
    tbl.push_back(mk(9,  1, 4'b1100, 1, 0, 0));
    tbl.push_back(mk(10, 1, 4'b0000, 1, 1, 1));
    tbl.push_back(mk(11, 1, 4'b0000, 1, 1, 2));
    tbl.push_back(mk(12, 1, 4'b0000, 1, 1, 3));
    tbl.push_back(mk(13, 1, 4'b0000, 1, 1, 4));
    tbl.push_back(mk(14, 1, 4'b0000, 1, 1, 5));
    tbl.push_back(mk(15, 1, 4'b0000, 1, 1, 6));
    tbl.push_back(mk(7,  1, 4'b1010, 1, 0, 6));
    tbl.push_back(mk(2,  0, 4'b1010, 0, 0, 6));
    tbl.push_back(mk(12, 0, 4'b1010, 0, 0, 6));

    rst_n = 1'b0; in_valid = 1'b0; {a, b, c, d} = 4'd0;
    m_x = 0; m_ov = 0; m_err = 0; m_cnt = 0;

    // Reset held for two cycles with a valid digit present.
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 5);
      check("rst_x",   dut_x(),         0);
      check("rst_ov",  int'(out_valid), 0);
      check("rst_err", int'(err),       0);
      check("rst_cnt", int'(err_cnt),   0);
    end

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      step(1, tbl[i].vld, tbl[i].v);
      check($sformatf("tbl%0d_x", i),   dut_x(),         tbl[i].ex);
      check($sformatf("tbl%0d_ov", i),  int'(out_valid), tbl[i].eov);
      check($sformatf("tbl%0d_err", i), int'(err),       tbl[i].eerr);
      check($sformatf("tbl%0d_cnt", i), int'(err_cnt),   tbl[i].ecnt);
    end

    // Mid-stream reset while err_cnt is non-zero, then resume with 9.
    for (int v = 0; v < 4; v++) step(1, 1, v);
    check("mid_pre_x", dut_x(), 4'b0110);
    step(0, 1, 4);
    check("mid_rst_x",   dut_x(),         0);
    check("mid_rst_cnt", int'(err_cnt),   0);
    check("mid_rst_ov",  int'(out_valid), 0);
    step(1, 1, 9);
    check("mid_resume_x",  dut_x(),         4'b1100);
    check("mid_resume_ov", int'(out_valid), 1);

    // Saturation: 300 invalid codes, counter must stick at 255.
    for (int i = 0; i < 300; i++) begin
      step(1, 1, $urandom_range(15, 10));
      if (i == 99 || i == 253 || i == 254 || i == 255 || i == 299)
        check($sformatf("sat%0d_cnt", i), int'(err_cnt), (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end
    check("sat_err", int'(err), 1);
    step(1, 1, 3);
    check("sat_hold_valid", int'(err_cnt), CNT_MAX);
    step(1, 1, 14);
    check("sat_hold_inv", int'(err_cnt), CNT_MAX);

    // Randomized run against the reference model, including occasional resets.
    step(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      int r, vld, v;
      r   = ($urandom_range(49, 0) == 0) ? 0 : 1;
      vld = ($urandom_range(3, 0) != 0) ? 1 : 0;
      v   = $urandom_range(15, 0);
      step(r, vld, v);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_ex3.md
Name: bcd_to_ex3

Overview:
- Converts one 4-bit BCD digit into its excess-3 code (value + 3), with registered outputs.
- Flags non-BCD input codes (10–15) and keeps a saturating count of them.
- Sits in the digit-encoding path ahead of excess-3 arithmetic and display logic.
- One clock domain; synchronous, active-low reset.

Parameters:
- ERR_CNT_W, 8, width of the saturating invalid-code counter.
- INVALID_OUT, 4'b0000, value driven on {s3,s2,s1,s0} when the input is not BCD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies a,b,c,d for the current cycle.
- a  input  1  BCD bit 3 (MSB).
- b  input  1  BCD bit 2.
- c  input  1  BCD bit 1.
- d  input  1  BCD bit 0 (LSB).
- s0  output  1  excess-3 bit 0 (LSB).
- s1  output  1  excess-3 bit 1.
- s2  output  1  excess-3 bit 2.
- s3  output  1  excess-3 bit 3 (MSB).
- out_valid  output  1  registered copy of in_valid.
- err  output  1  high with out_valid when the sampled input was 10–15.
- err_cnt  output  ERR_CNT_W  saturating count of accepted invalid inputs.

Behaviour:
- Input value v = {a,b,c,d}; output word x = {s3,s2,s1,s0}.
- Reset: when rst_n=0 at a rising clk edge, x=0000, out_valid=0, err=0, err_cnt=0. Reset overrides in_valid in the same cycle.
- Latency is exactly 1 cycle. On a rising edge with rst_n=1 and in_valid=1:
  - v in 0..9: x <= v+3 (4-bit, never overflows; range 0011..1100), err <= 0.
  - v in 10..15: x <= INVALID_OUT, err <= 1, err_cnt <= err_cnt+1, saturating at all-ones.
  - out_valid <= 1.
- On a rising edge with rst_n=1 and in_valid=0:
  - out_valid <= 0, err <= 0.
  - x holds its previous value.
  - err_cnt holds.
- Required mapping v -> x: 0->0011, 1->0100, 2->0101, 3->0110, 4->0111, 5->1000, 6->1001, 7->1010, 8->1011, 9->1100.
- Gate equations (v = 0..9) for a combinational core: s0=~d; s1=~(c^d); s2=b^(c|d); s3=a|(b&(c|d)).
- Invalid detect: a&(b|c).
- No combinational path from inputs to outputs.
- Back-to-back in_valid every cycle is supported at full throughput.
- Reset asserted mid-stream clears all state on the next edge; the first valid input after deassertion produces output one cycle later as normal.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, v=5 -> x=0000, out_valid=0, err=0, err_cnt=0.
- Sweep: after reset, in_valid=1, v=0..9 on consecutive cycles -> one cycle later x=0011,0100,…,1100 in order; out_valid=1; err=0.
- Invalid codes: v=10..15 with in_valid=1 -> x=0000, err=1 each cycle; err_cnt ends at 6.
- Hold: v=7 valid, then in_valid=0 with v=2 -> x stays 1010, out_valid=0.
- Saturation: 300 invalid inputs with ERR_CNT_W=8 -> err_cnt=255 and stays 255.
- Mid-stream reset: during the sweep assert rst_n=0 at v=4 -> next edge x=0000, err_cnt=0; resume with v=9 -> x=1100 one cycle after rst_n returns high.
